// File: rtl/button_events_if.sv
// Event handshake between button_events (master) and its consumer (slave).
interface button_events_if;
   logic       evt_valid;
   logic       evt_ready;
   logic [1:0] evt_btn;
   logic [1:0] evt_type;

   modport master (output evt_valid, output evt_btn, output evt_type, input evt_ready);
   modport slave  (input evt_valid, input evt_btn, input evt_type, output evt_ready);
endinterface

// File: rtl/button_events.sv
// button_events: turns four debounced button levels into PRESS / RELEASE /
// auto-repeat REPEAT events, staged through one pending slot per button and
// a 4-deep show-ahead FIFO with a valid/ready handshake.
module button_events #(
   parameter int CLK_DIV   = 50000,
   parameter int HOLD_MS   = 500,
   parameter int REPEAT_MS = 100
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [3:0]             btn_in,
   button_events_if.master        evt,
   output logic                   overflow,
   output logic [3:0]             held
);
   localparam int          DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [11:0] HOLD_T   = 12'(HOLD_MS);
   localparam logic [11:0] REPEAT_T = 12'(REPEAT_MS);
   localparam logic [1:0]  EV_PRESS = 2'd0, EV_RELEASE = 2'd1, EV_REPEAT = 2'd2;

   logic [DIV_W-1:0] r_div;
   logic             w_tick;
   logic [3:0]       r_btn_q;
   logic [11:0]      r_hcnt [4];
   logic [3:0]       r_phase;
   logic [3:0]       r_pv;
   logic [1:0]       r_pt [4];
   logic             r_ovf;
   logic [3:0]       r_mem [4];
   logic [1:0]       r_rd, r_wr;
   logic [2:0]       r_cnt;

   logic [3:0]       w_press, w_rel, w_rep, w_new, w_clr;
   logic [1:0]       w_ntype [4];
   logic [1:0]       w_sel;
   logic             w_push, w_pop, w_room;

   assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));

   // Free-running ms tick divider.
   always_ff @(posedge clk) begin
      if (reset)       r_div <= '0;
      else if (w_tick) r_div <= '0;
      else             r_div <= r_div + 1'b1;
   end

   // Edge detection and repeat-threshold detection per button.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_press[i] = btn_in[i] & ~r_btn_q[i];
         w_rel[i]   = ~btn_in[i] & r_btn_q[i];
         w_rep[i]   = ~w_press[i] & ~w_rel[i] & r_btn_q[i] & w_tick &
                      ((r_hcnt[i] + 12'd1) == (r_phase[i] ? REPEAT_T : HOLD_T));
         w_new[i]   = w_press[i] | w_rel[i] | w_rep[i];
         w_ntype[i] = w_press[i] ? EV_PRESS : (w_rel[i] ? EV_RELEASE : EV_REPEAT);
      end
   end

   // Lowest-index pending slot wins the single FIFO write port.
   always_comb begin
      w_sel = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (r_pv[i]) w_sel = 2'(i);
      w_pop  = evt.evt_valid & evt.evt_ready;
      w_room = (r_cnt < 3'd4) | w_pop;
      w_push = (|r_pv) & w_room;
      for (int i = 0; i < 4; i++)
         w_clr[i] = w_push && (w_sel == 2'(i));
   end

   // Button level register, hold counters and repeat phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_btn_q <= '0;
         r_phase <= '0;
         for (int i = 0; i < 4; i++) r_hcnt[i] <= '0;
      end else begin
         r_btn_q <= btn_in;
         for (int i = 0; i < 4; i++) begin
            if (w_press[i] | w_rel[i]) begin
               r_hcnt[i]  <= '0;
               r_phase[i] <= 1'b0;
            end else if (r_btn_q[i] & w_tick) begin
               if (w_rep[i]) begin
                  r_hcnt[i]  <= '0;
                  r_phase[i] <= 1'b1;
               end else begin
                  r_hcnt[i]  <= r_hcnt[i] + 12'd1;
               end
            end
         end
      end
   end

   // Pending slots: a new event overwrites, a FIFO write drains. A slot being
   // drained on the same edge it receives a new event is not a loss.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pv  <= '0;
         r_ovf <= 1'b0;
         for (int i = 0; i < 4; i++) r_pt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (w_new[i]) begin
               r_pv[i] <= 1'b1;
               r_pt[i] <= w_ntype[i];
            end else if (w_clr[i]) begin
               r_pv[i] <= 1'b0;
            end
         end
         if (|(w_new & r_pv & ~w_clr)) r_ovf <= 1'b1;
      end
   end

   // Show-ahead FIFO; push and pop on the same edge keep the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
         for (int i = 0; i < 4; i++) r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= {w_sel, r_pt[w_sel]};
            r_wr        <= r_wr + 2'd1;
         end
         if (w_pop) r_rd <= r_rd + 2'd1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 3'd1;
            2'b01:   r_cnt <= r_cnt - 3'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign evt.evt_valid = (r_cnt != 3'd0);
   assign evt.evt_btn   = r_mem[r_rd][3:2];
   assign evt.evt_type  = r_mem[r_rd][1:0];
   assign overflow      = r_ovf;
   assign held          = r_btn_q;
endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events: stimulus pushes expected events into a
// queue, a negedge monitor pops and compares on every accepted event.
module tb_button_events;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] btn_in = 4'd0;
   logic       overflow;
   logic [3:0] held;

   button_events_if bus ();

   button_events #(.CLK_DIV(10), .HOLD_MS(5), .REPEAT_MS(2)) dut (
      .clk(clk), .reset(reset), .btn_in(btn_in), .evt(bus),
      .overflow(overflow), .held(held)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int b; int t; int stamp; } exp_t;
   exp_t q[$];
   int checks = 0, errors = 0;
   int r0, c0;

   localparam int P = 0, R = 1, RP = 2;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic expect_evt(input int b, input int t, input int st);
      exp_t e;
      e.b = b; e.t = t; e.stamp = st;
      q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      btn_in = 4'd0;
      step(2);
      reset = 1'b0;
      q.delete();
      r0 = cyc;
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         step(1);
         n++;
      end
      chk(nm, q.size(), 0);
      q.delete();
   endtask

   // Scoreboard monitor: compare every accepted event against the queue head.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && bus.evt_valid && bus.evt_ready) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_evt got btn=%0d type=%0d want none", bus.evt_btn, bus.evt_type);
         end else begin
            e = q.pop_front();
            if (int'(bus.evt_btn) != e.b || int'(bus.evt_type) != e.t) begin
               errors++;
               $display("FAIL evt_order got btn=%0d type=%0d want btn=%0d type=%0d",
                        bus.evt_btn, bus.evt_type, e.b, e.t);
            end
            if (e.stamp >= 0) begin
               checks++;
               if (cyc != e.stamp) begin
                  errors++;
                  $display("FAIL evt_time got cycle %0d want %0d", cyc, e.stamp);
               end
            end
         end
      end
   end

   initial begin
      int v3[5];
      int v5[6];
      int v4[5];
      bus.evt_ready = 1'b1;

      // Hold button 2: PRESS, REPEAT after 5 ticks, then every 2 ticks, RELEASE.
      apply_reset();
      chk("rst_valid", int'(bus.evt_valid), 0);
      chk("rst_btn", int'(bus.evt_btn), 0);
      chk("rst_type", int'(bus.evt_type), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_held", int'(held), 0);
      step(9);
      btn_in = 4'b0100;
      expect_evt(2, P,  r0 + 11);
      expect_evt(2, RP, r0 + 61);
      expect_evt(2, RP, r0 + 81);
      expect_evt(2, RP, r0 + 101);
      expect_evt(2, R,  r0 + 111);
      step(1);
      chk("held_btn2", int'(held), 4);
      step(99);
      btn_in = 4'b0000;
      step(60);
      drain("hold_drain");

      // All four pressed in one cycle, then all released.
      apply_reset();
      btn_in = 4'hF;
      for (int i = 0; i < 4; i++) expect_evt(i, P, r0 + 2 + i);
      step(12);
      chk("all_press_ovf", int'(overflow), 0);
      btn_in = 4'h0;
      for (int i = 0; i < 4; i++) expect_evt(i, R, r0 + 14 + i);
      step(10);
      drain("all_drain");
      chk("all_release_ovf", int'(overflow), 0);

      // Stalled consumer: 4 queued, 5th held pending, all delivered in order.
      bus.evt_ready = 1'b0;
      apply_reset();
      v3 = '{1, 3, 2, 6, 4};
      expect_evt(0, P, -1); expect_evt(1, P, -1); expect_evt(0, R, -1);
      expect_evt(2, P, -1); expect_evt(1, R, -1);
      for (int k = 0; k < 5; k++) begin
         btn_in = v3[k][3:0];
         step(3);
      end
      step(2);
      chk("stall_valid", int'(bus.evt_valid), 1);
      chk("stall_head_btn", int'(bus.evt_btn), 0);
      chk("stall_head_type", int'(bus.evt_type), P);
      step(3);
      chk("stall_hold_btn", int'(bus.evt_btn), 0);
      chk("stall_hold_type", int'(bus.evt_type), P);
      chk("stall_ovf", int'(overflow), 0);
      bus.evt_ready = 1'b1;
      step(8);
      drain("stall_drain");
      chk("stall_end_ovf", int'(overflow), 0);

      // Full FIFO with two pending: push and pop together, head moves each cycle.
      bus.evt_ready = 1'b0;
      apply_reset();
      v5 = '{1, 3, 7, 15, 14, 6};
      expect_evt(0, P, -1); expect_evt(1, P, -1); expect_evt(2, P, -1);
      expect_evt(3, P, -1); expect_evt(0, R, -1); expect_evt(3, R, -1);
      for (int k = 0; k < 6; k++) begin
         btn_in = v5[k][3:0];
         step(2);
      end
      step(3);
      bus.evt_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         chk("full_pp_valid", int'(bus.evt_valid), 1);
         step(1);
      end
      chk("full_pp_empty", int'(bus.evt_valid), 0);
      drain("full_pp_drain");

      // Overwrite of pending RELEASE(1) by PRESS(1) while FIFO full.
      bus.evt_ready = 1'b0;
      apply_reset();
      v4 = '{1, 3, 2, 10, 8};
      expect_evt(0, P, -1); expect_evt(1, P, -1); expect_evt(0, R, -1);
      expect_evt(3, P, -1);
      for (int k = 0; k < 5; k++) begin
         btn_in = v4[k][3:0];
         step(2);
      end
      chk("ovf_before", int'(overflow), 0);
      btn_in = 4'b1010;
      expect_evt(1, P, -1);
      step(2);
      chk("ovf_set", int'(overflow), 1);
      bus.evt_ready = 1'b1;
      step(8);
      drain("ovf_drain");
      chk("ovf_sticky", int'(overflow), 1);
      btn_in = 4'b0010;
      expect_evt(3, R, -1);
      step(6);
      drain("ovf_traffic_drain");
      chk("ovf_sticky2", int'(overflow), 1);

      // Reset with three queued events and buttons held.
      bus.evt_ready = 1'b0;
      btn_in = 4'b0011; expect_evt(0, P, -1); step(2);
      btn_in = 4'b0010; expect_evt(0, R, -1); step(2);
      btn_in = 4'b0011; expect_evt(0, P, -1); step(3);
      chk("pre_rst_valid", int'(bus.evt_valid), 1);
      reset = 1'b1;
      step(1);
      chk("mid_rst_valid", int'(bus.evt_valid), 0);
      chk("mid_rst_ovf", int'(overflow), 0);
      chk("mid_rst_held", int'(held), 0);
      q.delete();
      reset = 1'b0;
      bus.evt_ready = 1'b1;
      c0 = cyc;
      expect_evt(0, P, c0 + 2);
      expect_evt(1, P, c0 + 3);
      step(10);
      drain("post_rst_drain");
      chk("post_rst_ovf", int'(overflow), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/button_events.md
# button_events

Converts the four debounced button levels from the button debouncer into discrete, queued user-input events: PRESS, RELEASE and auto-repeat REPEAT while a button is held. Events pass through a 4-entry FIFO with a valid/ready handshake to the camera control state machine, so a busy consumer never misses a keystroke. The block sits directly downstream of the debouncer and runs in the same system clock domain.

## Interface
- CLK_DIV, 50000: system clocks per 1 ms tick; tick period is exactly CLK_DIV cycles.
- HOLD_MS, 500: ticks a button must stay held before the first REPEAT; range 1..4095.
- REPEAT_MS, 100: ticks between subsequent REPEATs; range 1..4095.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- btn_in  in  4  debounced button levels, 1 = pressed; synchronous to clk.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts head this cycle.
- evt_btn  out  2  button index of head event.
- evt_type  out  2  0 = PRESS, 1 = RELEASE, 2 = REPEAT; 3 never produced.
- overflow  out  1  sticky, set when any event is lost; cleared only by reset.
- held  out  4  registered copy of btn_in (btn_q).

## Operation
- Reset values: evt_valid 0, evt_btn 0, evt_type 0, overflow 0, held 0, FIFO empty, all counters, pending flags and tick divider 0.
- A button held through reset yields a PRESS once reset deasserts (btn_q restarts at 0).
- Tick divider: counts 0..CLK_DIV-1, tick high for one cycle when count = CLK_DIV-1, then wraps to 0.
- Per button i, on each edge: btn_in[i]=1, btn_q[i]=0 -> pending PRESS; btn_in[i]=0, btn_q[i]=1 -> pending RELEASE; btn_q[i] <= btn_in[i].
- Per-button hold counter (12 bits) plus phase bit: cleared on any edge of button i; while btn_q[i]=1 increments on tick. Phase 0: at count = HOLD_MS raise pending REPEAT, clear count, phase <= 1. Phase 1: same at REPEAT_MS. Release clears count and phase.
- Each button has one pending slot (valid + type). A new event for a button whose slot is still valid overwrites it and sets overflow.
- Arbiter: each cycle, the lowest-index button with a valid pending slot is written to the FIFO if it has room; that slot clears. At most one FIFO write per cycle.
- FIFO: 4 entries of {btn, type}, show-ahead; head drives evt_btn/evt_type. Pop when evt_valid & evt_ready.
- Room = count < 4, or count = 4 with a pop in the same cycle (simultaneous push/pop on full permitted; count stays 4).
- Push and pop together at any count: count unchanged, order preserved.
- evt_btn/evt_type are don't-care when evt_valid=0 but must hold stable while evt_valid=1 and evt_ready=0.

## Timing
- btn_in change sampled at edge E0 sets the pending slot; FIFO write at E1; evt_valid high after E1 if FIFO was empty (2-cycle latency).
- REPEAT: pending set on the edge where tick coincides with threshold; same 1-cycle path to FIFO.
- Pop at edge with evt_valid & evt_ready; next entry presented immediately after that edge; evt_valid drops after the edge that pops the last entry, unless a push occurs on the same edge.
- Reset asserted mid-operation: at the next edge all state returns to reset values; queued events discarded.
- Worst-case overwrite: only if consumer stalls while the FIFO is full and the same button changes again.

## Test plan
- CLK_DIV=10, HOLD_MS=5, REPEAT_MS=2: press btn 2 and hold 100 cycles, evt_ready=1 -> PRESS(2) 2 cycles after edge, REPEAT(2) at 50 cycles, then every 20 cycles; release -> RELEASE(2) 2 cycles later, no further REPEATs.
- btn_in 0000 -> 1111 in one cycle, evt_ready=1 -> PRESS for btn 0,1,2,3 on four consecutive cycles, in index order; overflow stays 0.
- evt_ready=0; generate 5 press/release events across buttons 0-2 -> evt_valid=1, first 4 queued in order, 5th held pending; assert evt_ready -> all 5 delivered in order; overflow 0.
- FIFO full, evt_ready=0, pending RELEASE(1), then press btn 1 again -> overflow=1 and stays 1 after traffic resumes; RELEASE(1) never delivered, PRESS(1) delivered.
- FIFO full with evt_ready=1 and pending event -> pop and push on the same edge, count stays 4, head advances each cycle.
- Assert reset with 3 queued events and btn 0 held -> evt_valid=0, overflow=0, held=0 after the edge; PRESS(0) delivered 2 cycles after reset deasserts.
